// File: rtl/cordic_link_pkg.sv
// Shared constants and types for the CORDIC wrapper byte-serial link.
// Used by the host-side master (cordic_host_link) and the wrapper receive side.
//   N_TX_BYTES / N_RX_BYTES : packet lengths in each direction
//   tx_idx_t / rx_idx_t     : byte-index types sized from the packet lengths
//   link_state_e            : host master FSM states
//   tx_byte()               : selects outgoing byte idx of the {Y, X} operand pair
package cordic_link_pkg;

    localparam int N_TX_BYTES = 4;
    localparam int N_RX_BYTES = 6;

    localparam int TX_IDX_W = $clog2(N_TX_BYTES);
    localparam int RX_IDX_W = $clog2(N_RX_BYTES);

    typedef logic [TX_IDX_W-1:0] tx_idx_t;
    typedef logic [RX_IDX_W-1:0] rx_idx_t;

    localparam tx_idx_t TX_LAST = tx_idx_t'(N_TX_BYTES - 1);
    localparam rx_idx_t RX_LAST = rx_idx_t'(N_RX_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        RESP = 2'd3
    } link_state_e;

    // Byte order on the wire: x[7:0], x[15:8], y[7:0], y[15:8].
    function automatic logic [7:0] tx_byte(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input tx_idx_t     idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = x[7:0];
            2'd1:    b = x[15:8];
            2'd2:    b = y[7:0];
            default: b = y[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cordic_link_timer.sv
// Link inactivity timer. Counts enabled cycles since the last clear and flags
// expiry on the cycle whose increment would make the count reach LIMIT, so the
// owner can abort on the same edge the count reaches LIMIT.
// LIMIT = 0 disables expiry.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clr_i     : reload count to zero (has priority over en_i)
//   en_i      : count this cycle
//   expired_o : this cycle's increment reaches LIMIT (combinational)
module cordic_link_timer #(
    parameter int LIMIT = 1024,
    parameter int W     = 11
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign expired_o = (LIMIT != 0) && en_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cordic_host_link.sv
// Host-side master for the CORDIC wrapper byte-serial link.
// Accepts one (X, Y) command, sends it as 4 bytes on the IN channel, collects
// 6 result bytes on the OUT channel and returns magnitude/phase as one response.
// Every output comes straight from a register.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_x/cmd_y : client command channel
//   rsp_valid/rsp_ready/rsp_mag/rsp_phase/rsp_err : client response channel
//   busy                            : not IDLE
//   link_in_data/valid/ready        : bytes towards the wrapper
//   link_out_data/valid/ready       : bytes from the wrapper
module cordic_host_link
    import cordic_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_mag,
    output logic [31:0] rsp_phase,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  link_in_data,
    output logic        link_in_valid,
    input  logic        link_in_ready,
    input  logic [7:0]  link_out_data,
    input  logic        link_out_valid,
    output logic        link_out_ready
);

    localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    link_state_e state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    tx_idx_t     tx_q, tx_d;
    rx_idx_t     rx_q, rx_d;
    logic [47:0] res_q, res_d;      // {phase, mag}, filled byte by byte
    logic        err_q, err_d;

    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic        busy_q;
    logic [7:0]  in_data_q;
    logic        in_valid_q;
    logic        out_ready_q;

    logic        cmd_fire, in_fire, out_fire, rsp_fire;
    logic        tmr_clr, tmr_en, tmr_exp;

    assign cmd_fire = cmd_valid && cmd_ready_q;
    assign in_fire  = in_valid_q && link_in_ready;
    assign out_fire = out_ready_q && link_out_valid;
    assign rsp_fire = rsp_valid_q && rsp_ready;

    assign tmr_en = (state_q == SEND) || (state_q == RECV);

    cordic_link_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TCNT_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        res_d   = res_q;
        err_d   = err_q;
        tmr_clr = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    res_d   = '0;
                    err_d   = 1'b0;
                    tx_d    = '0;
                    tmr_clr = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (in_fire) begin
                    tmr_clr = 1'b1;
                    if (tx_q == TX_LAST) begin
                        rx_d    = '0;
                        state_d = RECV;
                    end else begin
                        tx_d = tx_q + tx_idx_t'(1);
                    end
                end else if (tmr_exp) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RECV: begin
                if (out_fire) begin
                    tmr_clr = 1'b1;
                    case (rx_q)
                        3'd0:    res_d[7:0]   = link_out_data;
                        3'd1:    res_d[15:8]  = link_out_data;
                        3'd2:    res_d[23:16] = link_out_data;
                        3'd3:    res_d[31:24] = link_out_data;
                        3'd4:    res_d[39:32] = link_out_data;
                        3'd5:    res_d[47:40] = link_out_data;
                        default: ;
                    endcase
                    if (rx_q == RX_LAST) begin
                        state_d = RESP;
                    end else begin
                        rx_d = rx_q + rx_idx_t'(1);
                    end
                end else if (tmr_exp) begin
                    // Partial result is kept; unreceived slots stay zero.
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with it;
    // the next IN byte is presented right after each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_data_q   <= '0;
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            res_q       <= res_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
            in_valid_q  <= (state_d == SEND);
            out_ready_q <= (state_d == RECV);
            in_data_q   <= (state_d == SEND) ? tx_byte(x_d, y_d, tx_d) : 8'h00;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_mag        = res_q[15:0];
    assign rsp_phase      = res_q[47:16];
    assign rsp_err        = err_q;
    assign busy           = busy_q;
    assign link_in_data   = in_data_q;
    assign link_in_valid  = in_valid_q;
    assign link_out_ready = out_ready_q;

endmodule
